// File: rtl/risc_mgmt_alu_arbiter_pkg.sv
// Shared types for the RISC-MGMT ALU arbiter: data word, ALU opcodes, arbiter states.
// ALU_ADD is encoded as zero so an idle extension port reads as all-zero.
package risc_mgmt_alu_arbiter_pkg;

    localparam int RMGMT_MAX_EXT = 8;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/risc_mgmt_alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo N.
// Reusable by any RISC-MGMT arbiter; no winner means o_onehot is all zero.
module rr_priority_pick
    import risc_mgmt_alu_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0] w_pos;
    logic           w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_pos    = '0;
        // One extra bit holds last+k before folding back into 0..N-1.
        for (int k = 1; k <= N; k++) begin
            w_pos = {1'b0, i_last} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(N)) begin
                w_pos = w_pos - (IDX_W+1)'(N);
            end
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_pos[IDX_W-1:0];
            end
        end
        if (w_found) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/risc_mgmt_alu_arbiter.sv
// Shares the execute-stage ALU between the core (always first) and N_EXT extensions, round-robin.
// Define RISC_MGMT_ALU_ARB_STATS_EN to add the stall_cnt / grant_cnt statistics outputs.
module risc_mgmt_alu_arbiter
    import risc_mgmt_alu_arbiter_pkg::*;
#(
    parameter int N_EXT = 4,
    parameter int IDX_W = idx_width(N_EXT)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             core_alu_req,
    input  logic [N_EXT-1:0] ext_req,
    input  word_t            ext_data_0 [N_EXT],
    input  word_t            ext_data_1 [N_EXT],
    input  aluop_t           ext_op     [N_EXT],
    output logic [N_EXT-1:0] ext_done,
    output logic [N_EXT-1:0] ext_busy,
    output word_t            ext_res,
    output logic             alu_sel_ext,
    output word_t            alu_port_a,
    output word_t            alu_port_b,
    output aluop_t           alu_op_ext,
    input  word_t            alu_res
`ifdef RISC_MGMT_ALU_ARB_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [15:0]      grant_cnt [N_EXT]
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_last_idx;
    word_t            r_res_q;
    logic [N_EXT-1:0] w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_load;
    logic             w_capture;
    logic             w_granted_req;

    rr_priority_pick #(
        .N     (N_EXT),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (ext_req),
        .i_last   (r_last_idx),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    assign w_granted_req = ext_req[r_grant_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        alu_sel_ext = 1'b0;
        ext_done    = '0;
        case (r_state)
            IDLE: begin
                if (|w_pick_onehot) begin
                    w_load      = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                // A dropped request aborts before the core check, so it never captures.
                if (!w_granted_req) begin
                    w_state_nxt = IDLE;
                end else if (!core_alu_req) begin
                    alu_sel_ext = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ext_done[r_grant_idx] = 1'b1;
                w_state_nxt           = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign alu_port_a = alu_sel_ext ? ext_data_0[r_grant_idx] : '0;
    assign alu_port_b = alu_sel_ext ? ext_data_1[r_grant_idx] : '0;
    assign alu_op_ext = alu_sel_ext ? ext_op[r_grant_idx] : ALU_ADD;
    assign ext_busy   = ext_req & ~ext_done;
    assign ext_res    = r_res_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_grant_idx <= '0;
            r_last_idx  <= IDX_W'(N_EXT - 1);
            r_res_q     <= '0;
        end else begin
            if (w_load) begin
                r_grant_idx <= w_pick_idx;
            end
            if (w_capture) begin
                r_res_q    <= alu_res;
                r_last_idx <= r_grant_idx;
            end
        end
    end

`ifdef RISC_MGMT_ALU_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_grant_cnt [N_EXT];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            for (int i = 0; i < N_EXT; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            if (r_state == EXEC && w_granted_req && core_alu_req && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            for (int i = 0; i < N_EXT; i++) begin
                if (w_capture && r_grant_idx == IDX_W'(i) && !(&r_grant_cnt[i])) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_risc_mgmt_alu_arbiter.sv
// Scoreboard bench for risc_mgmt_alu_arbiter: directed scenarios followed by random traffic.
module tb_risc_mgmt_alu_arbiter;
    import risc_mgmt_alu_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [31:0] res;
        int          due;
    } exp_t;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         core_alu_req;
    logic [N-1:0] ext_req;
    word_t        d0 [N];
    word_t        d1 [N];
    aluop_t       opv [N];
    logic [N-1:0] ext_done;
    logic [N-1:0] ext_busy;
    word_t        ext_res;
    logic         alu_sel_ext;
    word_t        alu_port_a;
    word_t        alu_port_b;
    aluop_t       alu_op_ext;
    word_t        alu_res;
    word_t        core_res;
`ifdef RISC_MGMT_ALU_ARB_STATS_EN
    logic [31:0]  stall_cnt;
    logic [15:0]  grant_cnt [N];
`endif

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic         mon_en = 1'b0;
    logic         exp_sel_now = 1'b0;
    logic [N-1:0] exp_done_m;
    exp_t         sbq [$];

    // Reference-side view of the requesters and the op in flight
    logic [N-1:0] active;
    int           done_at [N];
    logic         op_live;
    int           op_idx;
    int           op_grant;
    int           free_from;
    int           last_srv;
    logic         fix_en;
    word_t        fix_a;
    word_t        fix_b;
    aluop_t       fix_op;

    always #5 CLK = ~CLK;

    function automatic word_t alu_fn(input word_t a, input word_t b, input aluop_t op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return '0;
        endcase
    endfunction

    // Environment ALU: extension operands when selected, otherwise some core result.
    assign alu_res = alu_sel_ext ? alu_fn(alu_port_a, alu_port_b, alu_op_ext) : core_res;

    risc_mgmt_alu_arbiter #(.N_EXT(N)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .core_alu_req (core_alu_req),
        .ext_req      (ext_req),
        .ext_data_0   (d0),
        .ext_data_1   (d1),
        .ext_op       (opv),
        .ext_done     (ext_done),
        .ext_busy     (ext_busy),
        .ext_res      (ext_res),
        .alu_sel_ext  (alu_sel_ext),
        .alu_port_a   (alu_port_a),
        .alu_port_b   (alu_port_b),
        .alu_op_ext   (alu_op_ext),
        .alu_res      (alu_res)
`ifdef RISC_MGMT_ALU_ARB_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .grant_cnt    (grant_cnt)
`endif
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    // One clock of stimulus plus the reference prediction for that cycle.
    task automatic step(input logic [N-1:0] start, input logic [N-1:0] drop,
                        input logic core, input logic rstn);
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (active[i] && done_at[i] >= 0 && cyc > done_at[i]) active[i] = 1'b0;
            if (drop[i]) active[i] = 1'b0;
            if (start[i] && !active[i]) begin
                active[i]  = 1'b1;
                done_at[i] = -1;
                if (fix_en) begin
                    d0[i] = fix_a; d1[i] = fix_b; opv[i] = fix_op;
                end else begin
                    d0[i] = $urandom; d1[i] = $urandom; opv[i] = aluop_t'($urandom_range(0, 9));
                end
            end
        end
        ext_req      = active;
        core_alu_req = core;
        nRST         = rstn;
        core_res     = $urandom;
        exp_sel_now  = op_live && (cyc > op_grant) && active[op_idx] && !core;
        if (!rstn) begin
            exp_sel_now = 1'b0;
            op_live     = 1'b0;
            last_srv    = N - 1;
            free_from   = cyc + 1;
            while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
        end else if (op_live && cyc > op_grant) begin
            if (!active[op_idx]) begin
                op_live   = 1'b0;
                free_from = cyc + 1;
            end else if (!core) begin
                sbq.push_back('{idx: op_idx, res: alu_fn(d0[op_idx], d1[op_idx], opv[op_idx]), due: cyc + 1});
                done_at[op_idx] = cyc + 1;
                last_srv        = op_idx;
                op_live         = 1'b0;
                free_from       = cyc + 2;
            end
        end else if (!op_live && cyc >= free_from && active != '0) begin
            op_idx   = rr_pick(active, last_srv);
            op_live  = 1'b1;
            op_grant = cyc;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b1);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            exp_done_m = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_done_m[sbq[0].idx] = 1'b1;
                chk("done", 32'(ext_done), 32'(exp_done_m));
                chk("res", ext_res, sbq[0].res);
                void'(sbq.pop_front());
            end else begin
                chk("done", 32'(ext_done), 32'd0);
            end
            chk("busy", 32'(ext_busy), 32'(ext_req & ~exp_done_m));
            chk("sel", 32'(alu_sel_ext), 32'(exp_sel_now));
            if (!exp_sel_now) begin
                chk("port_a", alu_port_a, 32'd0);
                chk("port_b", alu_port_b, 32'd0);
                chk("op_ext", 32'(alu_op_ext), 32'(ALU_ADD));
            end
        end
    end

    initial begin
        nRST = 1'b0; core_alu_req = 1'b0; ext_req = '0; core_res = '0;
        active = '0; op_live = 1'b0; op_idx = 0; op_grant = 0;
        free_from = 0; last_srv = N - 1; fix_en = 1'b0;
        fix_a = '0; fix_b = '0; fix_op = ALU_ADD;
        for (int i = 0; i < N; i++) begin
            d0[i] = '0; d1[i] = '0; opv[i] = ALU_ADD; done_at[i] = -1;
        end

        // Reset values
        step('0, '0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step('0, '0, 1'b0, 1'b0);
        #2;
        chk("rst_res", ext_res, 32'd0);
        chk("rst_done", 32'(ext_done), 32'd0);
        chk("rst_sel", 32'(alu_sel_ext), 32'd0);

        // Single request: 5 + 7 from ext1
        fix_en = 1'b1; fix_a = 32'd5; fix_b = 32'd7; fix_op = ALU_ADD;
        step(4'b0010, '0, 1'b0, 1'b1);
        fix_en = 1'b0;
        step('0, '0, 1'b0, 1'b1);
        #2;
        chk("single_sel", 32'(alu_sel_ext), 32'd1);
        step('0, '0, 1'b0, 1'b1);
        #2;
        chk("single_done", 32'(ext_done), 32'b0010);
        chk("single_res", ext_res, 32'd12);
        idle_steps(3);

        // Fairness: everyone requests continuously from reset
        step(4'b1111, '0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(4'b1111, '0, 1'b0, 1'b1);
        idle_steps(20);

        // Core contention for four cycles during ext0's EXEC
        step('0, '0, 1'b0, 1'b0);
        step(4'b0001, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        #2;
        chk("cont_done", 32'(ext_done), 32'b0001);
`ifdef RISC_MGMT_ALU_ARB_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd4);
        chk("grant_cnt0", 32'(grant_cnt[0]), 32'd1);
`endif
        idle_steps(3);

        // Abort: ext2 granted then drops; ext3 served next
        step(4'b1100, '0, 1'b0, 1'b1);
        step('0, 4'b0100, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        #2;
        chk("abort_next", 32'(ext_done), 32'b1000);
        idle_steps(3);

        // Reset mid-operation, then rescan from index 0
        step(4'b0100, '0, 1'b0, 1'b1);
        idle_steps(4);
        step(4'b1000, '0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0);
        step('0, 4'b1000, 1'b0, 1'b1);
        #2;
        chk("midrst_done", 32'(ext_done), 32'd0);
        chk("midrst_res", ext_res, 32'd0);
        chk("midrst_sel", 32'(alu_sel_ext), 32'd0);
        step(4'b1010, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        #2;
        chk("midrst_rescan", 32'(ext_done), 32'b0010);
        idle_steps(10);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] st;
            for (int i = 0; i < N; i++) st[i] = ($urandom_range(0, 2) == 0);
            step(st, '0, ($urandom_range(0, 3) == 0), 1'b1);
        end
        idle_steps(30);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
